// File: rtl/mouse_pkg.sv
// Shared types and default widths for the mouse tracker stage.
package mouse_pkg;

  localparam int DEFAULT_WIDTH          = 16;
  localparam int DEFAULT_DELTA_WIDTH    = 9;
  localparam int DEFAULT_DEBOUNCE_COUNT = 3;

  typedef enum logic [1:0] {
    RELEASED        = 2'd0,
    PRESS_PENDING   = 2'd1,
    PRESSED         = 2'd2,
    RELEASE_PENDING = 2'd3
  } deb_state_t;

endpackage

// File: rtl/button_debouncer.sv
// Button debouncer: a level change is accepted only after DEBOUNCE_COUNT
// consecutive agreeing samples; advances only on cycles where step is high.
module button_debouncer
  import mouse_pkg::*;
#(
  parameter int DEBOUNCE_COUNT = DEFAULT_DEBOUNCE_COUNT
) (
  input  logic clock,
  input  logic reset,
  input  logic step,
  input  logic btn,
  output logic pressed_
);

  localparam int CW = (DEBOUNCE_COUNT < 2) ? 1 : $clog2(DEBOUNCE_COUNT + 1);
  localparam logic [CW-1:0] TARGET = CW'(DEBOUNCE_COUNT);

  deb_state_t    r_state, w_state_next;
  logic [CW-1:0] r_count, w_count_next;
  logic          r_pressed_n, w_pressed_n;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= RELEASED;
      r_count     <= '0;
      r_pressed_n <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_count     <= w_count_next;
      r_pressed_n <= w_pressed_n;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    if (step) begin
      case (r_state)
        RELEASED: if (btn) begin
          w_state_next = (DEBOUNCE_COUNT == 1) ? PRESSED : PRESS_PENDING;
          w_count_next = (DEBOUNCE_COUNT == 1) ? '0 : CW'(1);
        end
        PRESS_PENDING: begin
          if (!btn) begin
            w_state_next = RELEASED;
            w_count_next = '0;
          end else if (r_count + CW'(1) == TARGET) begin
            w_state_next = PRESSED;
            w_count_next = '0;
          end else begin
            w_count_next = r_count + CW'(1);
          end
        end
        PRESSED: if (!btn) begin
          w_state_next = (DEBOUNCE_COUNT == 1) ? RELEASED : RELEASE_PENDING;
          w_count_next = (DEBOUNCE_COUNT == 1) ? '0 : CW'(1);
        end
        RELEASE_PENDING: begin
          if (btn) begin
            w_state_next = PRESSED;
            w_count_next = '0;
          end else if (r_count + CW'(1) == TARGET) begin
            w_state_next = RELEASED;
            w_count_next = '0;
          end else begin
            w_count_next = r_count + CW'(1);
          end
        end
        default: begin
          w_state_next = RELEASED;
          w_count_next = '0;
        end
      endcase
    end
  end

  // Output is registered from the next state so it lines up with mouse_x.
  always_comb begin
    w_pressed_n = 1'b1;
    if (w_state_next == PRESSED || w_state_next == RELEASE_PENDING)
      w_pressed_n = 1'b0;
  end

  assign pressed_ = r_pressed_n;

endmodule

// File: rtl/mouse_tracker.sv
// Mouse tracker: one-deep packet register on a valid/ready input, saturating
// absolute X accumulator with a change pulse, and a debounced button.
module mouse_tracker
  import mouse_pkg::*;
#(
  parameter int                WIDTH          = DEFAULT_WIDTH,
  parameter int                DELTA_WIDTH    = DEFAULT_DELTA_WIDTH,
  parameter int                DEBOUNCE_COUNT = DEFAULT_DEBOUNCE_COUNT,
  parameter logic [WIDTH-1:0]  X_MAX          = '1,
  parameter logic [WIDTH-1:0]  X_RESET        = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_button,
  input  logic [DELTA_WIDTH-1:0] in_dx,
  output logic                   mouse_pressed_,
  output logic [WIDTH-1:0]       mouse_x,
  output logic                   moved
);

  localparam logic signed [WIDTH+1:0] X_MAX_S = {2'b00, X_MAX};

  logic                    r_pkt_full;
  logic                    r_pkt_button;
  logic [DELTA_WIDTH-1:0]  r_pkt_dx;
  logic [WIDTH-1:0]        r_mouse_x;
  logic                    r_moved;

  logic [WIDTH+1:0]        w_dx_ext;
  logic signed [WIDTH+1:0] w_sum;
  logic [WIDTH-1:0]        w_x_next;

  assign in_ready = ~reset & ~r_pkt_full;

  // Two guard bits keep both underflow and overflow visible before clamping.
  assign w_dx_ext = {{(WIDTH + 2 - DELTA_WIDTH){r_pkt_dx[DELTA_WIDTH-1]}}, r_pkt_dx};
  assign w_sum    = $signed({2'b00, r_mouse_x}) + $signed(w_dx_ext);

  always_comb begin
    w_x_next = w_sum[WIDTH-1:0];
    if (w_sum < 0)
      w_x_next = '0;
    else if (w_sum > X_MAX_S)
      w_x_next = X_MAX;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pkt_full <= 1'b0;
      r_mouse_x  <= X_RESET;
      r_moved    <= 1'b0;
    end else begin
      r_moved <= 1'b0;
      if (r_pkt_full) begin
        r_pkt_full <= 1'b0;
        r_mouse_x  <= w_x_next;
        r_moved    <= (w_x_next != r_mouse_x);
      end else if (in_valid && in_ready) begin
        r_pkt_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (in_valid && in_ready) begin
      r_pkt_button <= in_button;
      r_pkt_dx     <= in_dx;
    end
  end

  button_debouncer #(
    .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
  ) u_debouncer (
    .clock    (clock),
    .reset    (reset),
    .step     (r_pkt_full),
    .btn      (r_pkt_button),
    .pressed_ (mouse_pressed_)
  );

  assign mouse_x = r_mouse_x;
  assign moved   = r_moved;

endmodule

// File: tb/tb_mouse_tracker.sv
// Scoreboard bench for mouse_tracker: the driver queues the expected result of
// each accepted packet and a monitor compares it on the apply cycle.
module tb_mouse_tracker;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_button;
  logic [8:0]  in_dx;
  logic        mouse_pressed_;
  logic [15:0] mouse_x;
  logic        moved;

  typedef struct {
    logic [15:0] x;
    logic        mv;
    logic        p;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_accept = -1;
  bit   gap_check = 1'b0;
  bit   st1 = 1'b0;
  bit   st2 = 1'b0;

  mouse_tracker dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_button      (in_button),
    .in_dx          (in_dx),
    .mouse_pressed_ (mouse_pressed_),
    .mouse_x        (mouse_x),
    .moved          (moved)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: accept seen at negedge k applies at posedge k+2 unless reset at k+2.
  always @(negedge clock) begin
    exp_t e;
    if (st2) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL apply: result x=%0h with empty scoreboard", mouse_x);
      end else begin
        e = sb.pop_front();
        chk("mouse_x", 32'(mouse_x), 32'(e.x));
        chk("moved", 32'(moved), 32'(e.mv));
        chk("pressed_", 32'(mouse_pressed_), 32'(e.p));
        $display("apply: x=%0h moved=%0b pressed_=%0b", mouse_x, moved, mouse_pressed_);
      end
    end else begin
      chk("moved_idle", 32'(moved), 32'd0);
    end
    st2 = st1 && !reset;
    st1 = in_valid && in_ready;
  end

  task automatic send(input logic b, input int dx, input logic [15:0] ex,
                      input logic em, input logic ep, input bit expect_apply);
    bit got;
    exp_t e;
    in_valid  = 1'b1;
    in_button = b;
    in_dx     = dx[8:0];
    got = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clock);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1");
    end else begin
      if (gap_check && last_accept >= 0)
        chk("accept_gap", 32'(cyc - last_accept), 32'd2);
      last_accept = cyc;
      if (expect_apply) begin
        e.x = ex; e.mv = em; e.p = ep;
        sb.push_back(e);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    last_accept = -1;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b1;
    in_button = 1'b1;
    in_dx = 9'd5;
    repeat (2) begin
      @(negedge clock);
      chk("ready_in_reset", 32'(in_ready), 32'd0);
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    chk("rst_mouse_x", 32'(mouse_x), 32'd0);
    chk("rst_pressed_", 32'(mouse_pressed_), 32'd1);
    chk("rst_moved", 32'(moved), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_button = 1'b0; in_dx = '0;
    #1;
    // 1: reset with valid held high
    do_reset();

    // 2: back-to-back handshake, valid never dropped
    gap_check = 1'b1;
    send(1'b0,  5, 16'd5, 1'b1, 1'b1, 1'b1);
    send(1'b0, -5, 16'd0, 1'b1, 1'b1, 1'b1);
    send(1'b0,  0, 16'd0, 1'b0, 1'b1, 1'b1);
    send(1'b0, -1, 16'd0, 1'b0, 1'b1, 1'b1);

    // 3: climb to 16'hFFFD then saturate at the top
    for (int i = 0; i < 256; i++)
      send(1'b0, 255, 16'(255 * (i + 1)), 1'b1, 1'b1, 1'b1);
    send(1'b0, 253, 16'hFFFD, 1'b1, 1'b1, 1'b1);
    send(1'b0,  10, 16'hFFFF, 1'b1, 1'b1, 1'b1);
    send(1'b0,  10, 16'hFFFF, 1'b0, 1'b1, 1'b1);
    idle(3);
    gap_check = 1'b0;
    do_reset();
    send(1'b0,    3, 16'd3, 1'b1, 1'b1, 1'b1);
    send(1'b0, -256, 16'd0, 1'b1, 1'b1, 1'b1);
    send(1'b0, -256, 16'd0, 1'b0, 1'b1, 1'b1);

    // 4: debounce with an interrupted press, then a short glitch while pressed
    send(1'b1, 0, 16'd0, 1'b0, 1'b1, 1'b1);
    send(1'b1, 0, 16'd0, 1'b0, 1'b1, 1'b1);
    send(1'b0, 0, 16'd0, 1'b0, 1'b1, 1'b1);
    send(1'b1, 0, 16'd0, 1'b0, 1'b1, 1'b1);
    send(1'b1, 0, 16'd0, 1'b0, 1'b1, 1'b1);
    send(1'b1, 0, 16'd0, 1'b0, 1'b0, 1'b1);
    send(1'b0, 0, 16'd0, 1'b0, 1'b0, 1'b1);
    send(1'b1, 0, 16'd0, 1'b0, 1'b0, 1'b1);

    // 5: release, with simultaneous movement
    send(1'b0, 2, 16'd2, 1'b1, 1'b0, 1'b1);
    send(1'b0, 0, 16'd2, 1'b0, 1'b0, 1'b1);
    send(1'b0, 1, 16'd3, 1'b1, 1'b1, 1'b1);
    idle(3);
    do_reset();

    // 6: reset the cycle after accept drops the latched packet
    send(1'b1, 7, 16'd0, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("drop_mouse_x", 32'(mouse_x), 32'd0);
      chk("drop_moved", 32'(moved), 32'd0);
      chk("drop_pressed_", 32'(mouse_pressed_), 32'd1);
    end
    idle(2);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
